// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use bubbles, taken-branch squash, multi-cycle windows.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int STALL_CYC = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [2:0]       IDEX_RTaddr_i,
    input  logic [2:0]       IFID_RSaddr_i,
    input  logic [2:0]       IFID_RTaddr_i,
    input  logic             IFID_UsesRT_i,
    input  logic             BranchTaken_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IDEXWrite_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Flush_o,
    output logic             Busy_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Control bundle order: {PCWrite, IFIDWrite, IDEXWrite, IFID_Flush, IDEX_Flush}
    localparam logic [4:0] CTL_PASS  = 5'b11111;
    localparam logic [4:0] CTL_STALL = 5'b00011;
    localparam logic [4:0] CTL_FLUSH = 5'b11100;

    localparam logic [2:0] STALL_LD = 3'(STALL_CYC - 1);
    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] ctl;
    logic       lu;
    logic       stall_evt;
    logic       flush_evt;

    // Register 0 is hardwired zero, so it never creates a dependency.
    assign lu = IDEX_MemRead_i && (IDEX_RTaddr_i != 3'd0) &&
                ((IDEX_RTaddr_i == IFID_RSaddr_i) ||
                 (IFID_UsesRT_i && (IDEX_RTaddr_i == IFID_RTaddr_i)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctl       = CTL_PASS;
        stall_evt = 1'b0;
        flush_evt = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (BranchTaken_i) begin
                    ctl       = CTL_FLUSH;
                    flush_evt = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LD;
                    end
                end else if (lu) begin
                    ctl       = CTL_STALL;
                    stall_evt = 1'b1;
                    if (STALL_CYC > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_LD;
                    end
                end
            end

            STALL: begin
                // A taken branch makes the stalled instruction wrong-path; squash instead.
                if (BranchTaken_i) begin
                    ctl       = CTL_FLUSH;
                    flush_evt = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    ctl = CTL_STALL;
                    if (cnt_q <= 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end

            FLUSH: begin
                ctl = CTL_FLUSH;
                if (cnt_q <= 3'd1) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (rst_i) begin
            ctl       = CTL_PASS;
            state_d   = IDLE;
            cnt_d     = 3'd0;
            stall_evt = 1'b0;
            flush_evt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    assign {PCWrite_o, IFIDWrite_o, IDEXWrite_o, IFID_Flush_o, IDEX_Flush_o} = ctl;
    assign Busy_o = (state_q != IDLE);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;
    assign FlushCnt_o = flush_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
    assign StallCnt_o = '0;
    assign FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with different window lengths.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] PASS  = 5'b11111;
    localparam logic [4:0] STL   = 5'b00011;
    localparam logic [4:0] FLS   = 5'b11100;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       mr;
    logic [2:0] rte, rs, rt;
    logic       usesrt;
    logic       br;

    always #5 clk = ~clk;

    logic        a_pc, a_ifw, a_idw, a_iff, a_idf, a_busy;
    logic        b_pc, b_ifw, b_idw, b_iff, b_idf, b_busy;
    logic        c_pc, c_ifw, c_idw, c_iff, c_idf, c_busy;
    logic [15:0] a_sc, a_fc, b_sc, b_fc, c_sc, c_fc;
    logic [4:0]  ctl_a, ctl_b, ctl_c;

    assign ctl_a = {a_pc, a_ifw, a_idw, a_iff, a_idf};
    assign ctl_b = {b_pc, b_ifw, b_idw, b_iff, b_idf};
    assign ctl_c = {c_pc, c_ifw, c_idw, c_iff, c_idf};

    pipe_hazard_ctrl #(.STALL_CYC(1), .FLUSH_CYC(1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(rte),
        .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt), .IFID_UsesRT_i(usesrt), .BranchTaken_i(br),
        .PCWrite_o(a_pc), .IFIDWrite_o(a_ifw), .IDEXWrite_o(a_idw), .IFID_Flush_o(a_iff),
        .IDEX_Flush_o(a_idf), .Busy_o(a_busy), .StallCnt_o(a_sc), .FlushCnt_o(a_fc));

    pipe_hazard_ctrl #(.STALL_CYC(3), .FLUSH_CYC(2), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(rte),
        .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt), .IFID_UsesRT_i(usesrt), .BranchTaken_i(br),
        .PCWrite_o(b_pc), .IFIDWrite_o(b_ifw), .IDEXWrite_o(b_idw), .IFID_Flush_o(b_iff),
        .IDEX_Flush_o(b_idf), .Busy_o(b_busy), .StallCnt_o(b_sc), .FlushCnt_o(b_fc));

    pipe_hazard_ctrl #(.STALL_CYC(3), .FLUSH_CYC(4), .CNT_W(16)) u_c (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(rte),
        .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt), .IFID_UsesRT_i(usesrt), .BranchTaken_i(br),
        .PCWrite_o(c_pc), .IFIDWrite_o(c_ifw), .IDEXWrite_o(c_idw), .IFID_Flush_o(c_iff),
        .IDEX_Flush_o(c_idf), .Busy_o(c_busy), .StallCnt_o(c_sc), .FlushCnt_o(c_fc));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_in();
        mr = 1'b0; rte = 3'd0; rs = 3'd0; rt = 3'd0; usesrt = 1'b0; br = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        tick();
        // reset dominates even with a branch and a hazard present
        br = 1'b1; mr = 1'b1; rte = 3'd3; rs = 3'd3;
        smp();
        chk("rst_pass_a", ctl_a, PASS);
        chk("rst_pass_b", ctl_b, PASS);
        tick();
        rst = 1'b0;
        clr_in();
        smp();
        chk("post_rst_ctl", ctl_b, PASS);
        chk("post_rst_busy", b_busy, 0);
        chk("post_rst_sc", b_sc, 0);
        chk("post_rst_fc", b_fc, 0);
        tick();

        // single-cycle load-use stall
        mr = 1'b1; rte = 3'd3; rs = 3'd3;
        smp();
        chk("lu1_ctl", ctl_a, STL);
        chk("lu1_busy", a_busy, 0);
        tick();
        clr_in();
        smp();
        chk("lu1_next_ctl", ctl_a, PASS);
        chk("lu1_next_busy", a_busy, 0);
        chk("lu1_sc", a_sc, PERF ? 1 : 0);
        tick();

        // r0 and unused RT never stall; used RT does
        mr = 1'b1; rte = 3'd0; rs = 3'd0; rt = 3'd0; usesrt = 1'b1;
        smp();
        chk("r0_nostall", ctl_a, PASS);
        tick();
        rte = 3'd5; rs = 3'd2; rt = 3'd5; usesrt = 1'b0;
        smp();
        chk("rt_unused", ctl_a, PASS);
        tick();
        usesrt = 1'b1;
        smp();
        chk("rt_used", ctl_a, STL);
        tick();
        clr_in();
        br = 1'b1;
        smp();
        chk("fl1_ctl", ctl_a, FLS);
        chk("fl1_busy", a_busy, 0);
        tick();
        br = 1'b0;
        smp();
        chk("fl1_next", ctl_a, PASS);
        tick();

        // three-cycle stall window
        do_reset();
        mr = 1'b1; rte = 3'd3; rs = 3'd3;
        smp();
        chk("s3_c1_ctl", ctl_b, STL);
        chk("s3_c1_busy", b_busy, 0);
        tick();
        smp();
        chk("s3_c2_ctl", ctl_b, STL);
        chk("s3_c2_busy", b_busy, 1);
        tick();
        smp();
        chk("s3_c3_ctl", ctl_b, STL);
        chk("s3_c3_busy", b_busy, 1);
        tick();
        mr = 1'b0;
        smp();
        chk("s3_c4_ctl", ctl_b, PASS);
        chk("s3_c4_busy", b_busy, 0);
        chk("s3_sc", b_sc, PERF ? 1 : 0);
        tick();

        // branch beats load-use; second branch inside FLUSH ignored
        do_reset();
        mr = 1'b1; rte = 3'd3; rs = 3'd3; br = 1'b1;
        smp();
        chk("f2_c1_ctl", ctl_b, FLS);
        chk("f2_c1_busy", b_busy, 0);
        tick();
        smp();
        chk("f2_c2_ctl", ctl_b, FLS);
        chk("f2_c2_busy", b_busy, 1);
        tick();
        clr_in();
        smp();
        chk("f2_c3_ctl", ctl_b, PASS);
        chk("f2_c3_busy", b_busy, 0);
        chk("f2_fc", b_fc, PERF ? 1 : 0);
        chk("f2_sc", b_sc, 0);
        tick();

        // branch aborts a stall in its second cycle
        do_reset();
        mr = 1'b1; rte = 3'd3; rs = 3'd3;
        smp();
        chk("ab_c1_ctl", ctl_b, STL);
        tick();
        br = 1'b1;
        smp();
        chk("ab_c2_ctl", ctl_b, FLS);
        chk("ab_c2_busy", b_busy, 1);
        tick();
        br = 1'b0;
        smp();
        chk("ab_c3_ctl", ctl_b, FLS);
        tick();
        mr = 1'b0;
        smp();
        chk("ab_c4_ctl", ctl_b, PASS);
        chk("ab_c4_busy", b_busy, 0);
        chk("ab_sc", b_sc, PERF ? 1 : 0);
        chk("ab_fc", b_fc, PERF ? 1 : 0);
        tick();

        // reset in mid flush window abandons it
        do_reset();
        br = 1'b1;
        smp();
        chk("rf_c1_ctl", ctl_c, FLS);
        chk("rf_c1_busy", c_busy, 0);
        tick();
        br = 1'b0;
        rst = 1'b1;
        smp();
        chk("rf_rst_ctl", ctl_c, PASS);
        tick();
        rst = 1'b0;
        smp();
        chk("rf_rel_ctl", ctl_c, PASS);
        chk("rf_rel_busy", c_busy, 0);
        chk("rf_rel_fc", c_fc, 0);
        chk("rf_rel_sc", c_sc, 0);
        tick();
        smp();
        chk("rf_after_ctl", ctl_c, PASS);
        chk("rf_after_busy", c_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard/flush controller that drives the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards between ID and EX and inserts bubbles.
- Squashes wrong-path instructions after a taken branch or jump resolves in EX.
- Holds multi-cycle stall/flush windows in a small FSM with a down-counter; optional saturating event counters.

Parameters:
- STALL_CYC, 1, bubble cycles per load-use hazard (legal 1..7)
- FLUSH_CYC, 1, cycles IF/ID and ID/EX are squashed per taken branch/jump (legal 1..7)
- CNT_W, 16, width of performance counters

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_RTaddr_i  in  3  load destination register in EX
- IFID_RSaddr_i  in  3  RS of instruction in ID
- IFID_RTaddr_i  in  3  RT of instruction in ID
- IFID_UsesRT_i  in  1  ID instruction reads RT as a source
- BranchTaken_i  in  1  EX resolved a taken branch or a jump this cycle
- PCWrite_o  out  1  1 = PC updates
- IFIDWrite_o  out  1  1 = IF/ID register loads
- IDEXWrite_o  out  1  0 = ID/EX control fields forced to zero (bubble)
- IFID_Flush_o  out  1  active-low; 0 = IF/ID squashed
- IDEX_Flush_o  out  1  active-low; 0 = ID/EX control fields forced to zero
- Busy_o  out  1  FSM not in IDLE
- StallCnt_o  out  CNT_W  load-use events (PERF_CNT_EN only, else 0)
- FlushCnt_o  out  CNT_W  taken-branch events (PERF_CNT_EN only, else 0)

Behaviour:
- Hazard condition:
  - lu = IDEX_MemRead_i & (IDEX_RTaddr_i != 0) & ((IDEX_RTaddr_i == IFID_RSaddr_i) | (IFID_UsesRT_i & IDEX_RTaddr_i == IFID_RTaddr_i)).
  - Register 0 never causes a stall.
- Outputs are combinational from the current state and inputs, with zero-cycle latency: the hazard is acted on in the same cycle it is detected.
- Pass values: PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFID_Flush=1, IDEX_Flush=1.
- Stall values: PCWrite=0, IFIDWrite=0, IDEXWrite=0, both flushes=1.
- Flush values: PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFID_Flush=0, IDEX_Flush=0.
- FSM states: IDLE, STALL, FLUSH; 3-bit down-counter cnt.
- IDLE:
  - BranchTaken_i: drive flush values. If FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-1; else stay IDLE.
  - else if lu: drive stall values. If STALL_CYC>1, go to STALL with cnt=STALL_CYC-1; else stay IDLE.
  - else: drive pass values.
- STALL:
  - Drive stall values; cnt decrements each cycle; return to IDLE when cnt==1.
  - BranchTaken_i in STALL aborts the stall: drive flush values that cycle and enter the FLUSH path exactly as from IDLE.
  - lu re-evaluation is ignored until back in IDLE.
- FLUSH:
  - Drive flush values; cnt decrements; return to IDLE when cnt==1.
  - BranchTaken_i and lu are ignored, since the instructions raising them are wrong-path.
- Priority: branch/jump flush > load-use stall > pass.
- Busy_o = (state != IDLE).
- Reset:
  - rst_i high forces state to IDLE, cnt to 0 and counters to 0 at the next edge.
  - While rst_i is high, outputs show pass values, regardless of current state.
  - Reset in mid-STALL or mid-FLUSH abandons the window; no residual stall or flush after release.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - StallCnt_o increments by 1 on every cycle that enters a load-use stall from IDLE; continuation cycles are not counted.
  - FlushCnt_o increments on every accepted BranchTaken_i.
  - Both counters saturate at all-ones and clear on rst_i.
- Undefined: counter registers are absent and both outputs are tied to 0.

Test Plan:
- STALL_CYC=1: IDEX_MemRead_i=1, IDEX_RTaddr_i=3, IFID_RSaddr_i=3 for one cycle -> that cycle PCWrite/IFIDWrite/IDEXWrite=0; next cycle (hazard removed) all pass values; Busy_o stays 0.
- Same as above but IDEX_RTaddr_i=0, or RT match with IFID_UsesRT_i=0 -> no stall, pass values every cycle.
- STALL_CYC=3: lu held high -> exactly 3 consecutive stall cycles, Busy_o=1 during cycles 2-3, then IDLE. With PERF_CNT_EN, StallCnt_o=1.
- FLUSH_CYC=2: BranchTaken_i pulse while lu=1 -> flush wins: IFID_Flush_o=IDEX_Flush_o=0 for 2 cycles with PCWrite=1. A second BranchTaken_i during the FLUSH cycle is ignored, so FlushCnt_o=1.
- STALL_CYC=3: BranchTaken_i asserted in the 2nd stall cycle -> flush values in that cycle, stall aborted, no further stall cycles.
- FLUSH_CYC=4: rst_i asserted in the 2nd flush cycle -> pass values while rst_i is high; after release state is IDLE, outputs pass, Busy_o=0, counters 0.
